// File: rtl/user_clock_ratio_gen.sv
// Fractional clock-enable generator: NCH channels emit CE pulses at M/D of CLK
// and a lock/reset FSM. Optional runtime reconfig: USER_CLOCK_RECONFIG_EN.
//   in : CLK, RST_N (async, active-low), CFG_EN, CFG_CH, CFG_MULT, CFG_DIV
//   out: CFG_RDY, CFG_ERR, CE_OUT[NCH], LOCKED_OUT, RST_N_OUT
`timescale 1ns/1ps
module user_clock_ratio_gen #(
  parameter int NCH = 2,
  parameter int ACC_W = 6,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NCH*ACC_W-1:0] INIT_MULT = {NCH{6'd1}},
  parameter logic [NCH*ACC_W-1:0] INIT_DIV  = {NCH{6'd2}}
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CFG_EN,
  input  logic [2:0]       CFG_CH,
  input  logic [ACC_W-1:0] CFG_MULT,
  input  logic [ACC_W-1:0] CFG_DIV,
  output logic             CFG_RDY,
  output logic             CFG_ERR,
  output logic [NCH-1:0]   CE_OUT,
  output logic             LOCKED_OUT,
  output logic             RST_N_OUT
);

  localparam logic [1:0] RESET     = 2'd0;
  localparam logic [1:0] WAIT_LOCK = 2'd1;
  localparam logic [1:0] LOCKED    = 2'd2;
  localparam logic [1:0] RECONFIG  = 2'd3;

  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [15:0]      lock_cnt_q, lock_cnt_d;
  logic [ACC_W-1:0] mult_q [NCH];
  logic [ACC_W-1:0] div_q  [NCH];
  logic [ACC_W-1:0] acc_q  [NCH];
  logic [ACC_W-1:0] acc_d  [NCH];
  logic [NCH-1:0]   hit;
  logic [NCH-1:0]   ce_q;
  logic             err_q;
  logic             cfg_fire;
  logic             cfg_bad;
  logic             cfg_ok;
  logic             run;

`ifdef USER_CLOCK_RECONFIG_EN
  assign cfg_fire = CFG_EN && (state_q == LOCKED);
  assign cfg_bad  = (CFG_MULT == '0) || (CFG_DIV == '0) ||
                    (CFG_MULT > CFG_DIV) ||
                    ({29'd0, CFG_CH} >= 32'(NCH));
  assign CFG_RDY  = (state_q == LOCKED);
`else
  logic unused_cfg;
  assign unused_cfg = ^{CFG_EN, CFG_CH, CFG_MULT, CFG_DIV};
  assign cfg_fire = 1'b0;
  assign cfg_bad  = 1'b0;
  assign CFG_RDY  = 1'b0;
`endif

  assign cfg_ok = cfg_fire & ~cfg_bad;

  // An accepted request clears every channel on the same edge so that
  // all phases restart together.
  assign run = (state_q == WAIT_LOCK) ||
               ((state_q == LOCKED) && !cfg_ok);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [ACC_W:0] nxt;
    logic [ACC_W:0] sub;
    assign nxt      = {1'b0, acc_q[g]} + {1'b0, mult_q[g]};
    assign sub      = nxt - {1'b0, div_q[g]};
    assign hit[g]   = (nxt >= {1'b0, div_q[g]});
    assign acc_d[g] = hit[g] ? sub[ACC_W-1:0] : nxt[ACC_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      RESET: begin
        state_d    = WAIT_LOCK;
        lock_cnt_d = '0;
      end
      WAIT_LOCK: begin
        if (lock_cnt_q == LOCK_LAST) begin
          state_d    = LOCKED;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 16'd1;
        end
      end
      LOCKED: begin
        if (cfg_ok) state_d = RECONFIG;
      end
      RECONFIG: begin
        state_d    = WAIT_LOCK;
        lock_cnt_d = '0;
      end
      default: state_d = RESET;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= RESET;
      lock_cnt_q <= '0;
      ce_q       <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        acc_q[i]  <= '0;
        mult_q[i] <= INIT_MULT[i*ACC_W +: ACC_W];
        div_q[i]  <= INIT_DIV[i*ACC_W +: ACC_W];
      end
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      err_q      <= cfg_fire & cfg_bad;
      for (int i = 0; i < NCH; i++) begin
        if (run) begin
          acc_q[i] <= acc_d[i];
          ce_q[i]  <= hit[i];
        end else begin
          acc_q[i] <= '0;
          ce_q[i]  <= 1'b0;
        end
        if (cfg_ok && (CFG_CH == 3'(i))) begin
          mult_q[i] <= CFG_MULT;
          div_q[i]  <= CFG_DIV;
        end
      end
    end
  end

  assign CE_OUT     = ce_q;
  assign CFG_ERR    = err_q;
  assign LOCKED_OUT = (state_q == LOCKED);
  assign RST_N_OUT  = LOCKED_OUT;

endmodule

// File: tb/tb_user_clock_ratio_gen.sv
// Directed bench for user_clock_ratio_gen: ch0 at 1/4, ch1 at 3/8,
// lock timing, density, reconfig/reject (when enabled), async reset.
`timescale 1ns/1ps
module tb_user_clock_ratio_gen;

  logic       clk;
  logic       rst_n;
  logic       cfg_en;
  logic [2:0] cfg_ch;
  logic [5:0] cfg_mult;
  logic [5:0] cfg_div;
  logic       cfg_rdy;
  logic       cfg_err;
  logic [1:0] ce;
  logic       locked;
  logic       rst_n_out;

  int errors;
  int checks;

  // ch1 3/8 pattern after a phase clear: bit k-1 is CE on edge k
  logic [7:0] p1;

  user_clock_ratio_gen #(
    .NCH(2),
    .ACC_W(6),
    .LOCK_CYCLES(16),
    .INIT_MULT({6'd3, 6'd1}),
    .INIT_DIV({6'd8, 6'd4})
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .CFG_EN(cfg_en),
    .CFG_CH(cfg_ch),
    .CFG_MULT(cfg_mult),
    .CFG_DIV(cfg_div),
    .CFG_RDY(cfg_rdy),
    .CFG_ERR(cfg_err),
    .CE_OUT(ce),
    .LOCKED_OUT(locked),
    .RST_N_OUT(rst_n_out)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({ce, locked, rst_n_out, cfg_rdy, cfg_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b want 000000",
               {ce, locked, rst_n_out, cfg_rdy, cfg_err});
    end
  endtask

  task automatic test_lock;
    logic e0, e1, el;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ce, locked} !== 3'b0) begin
      errors++;
      $display("FAIL lock_e0: got %b want 000", {ce, locked});
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      e0 = (k % 4 == 0);
      e1 = p1[(k-1)%8];
      el = (k >= 16);
      checks++;
      if ({ce[0], ce[1], locked, rst_n_out} !== {e0, e1, el, el}) begin
        errors++;
        $display("FAIL lock_edge%0d: got %b want %b", k,
                 {ce[0], ce[1], locked, rst_n_out}, {e0, e1, el, el});
      end
    end
  endtask

  task automatic test_density;
    int c0, c1, idle, maxgap, unl;
    c0 = 0; c1 = 0; idle = 0; maxgap = 0; unl = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (ce[0]) c0++;
      if (ce[1]) begin
        c1++;
        idle = 0;
      end else begin
        idle++;
        if (idle > maxgap) maxgap = idle;
      end
      if (locked !== 1'b1) unl++;
    end
    checks++;
    if (c1 !== 300) begin
      errors++;
      $display("FAIL dens_ch1: got %0d want 300", c1);
    end
    checks++;
    if (c0 !== 200) begin
      errors++;
      $display("FAIL dens_ch0: got %0d want 200", c0);
    end
    checks++;
    if (maxgap > 3) begin
      errors++;
      $display("FAIL gap_ch1: got %0d want <=3", maxgap);
    end
    checks++;
    if (unl !== 0) begin
      errors++;
      $display("FAIL stay_locked: got %0d unlocked want 0", unl);
    end
  endtask

`ifdef USER_CLOCK_RECONFIG_EN
  task automatic test_reconfig;
    logic e1, el;
    checks++;
    if (cfg_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rdy_locked: got %b want 1", cfg_rdy);
    end
    cfg_en = 1'b1; cfg_ch = 3'd0; cfg_mult = 6'd2; cfg_div = 6'd2;
    @(negedge clk);
    cfg_en = 1'b0;
    checks++;
    if ({cfg_rdy, locked, rst_n_out, ce, cfg_err} !== 6'b0) begin
      errors++;
      $display("FAIL reconf_enter: got %b want 000000",
               {cfg_rdy, locked, rst_n_out, ce, cfg_err});
    end
    @(negedge clk);
    checks++;
    if ({cfg_rdy, locked, ce} !== 4'b0) begin
      errors++;
      $display("FAIL reconf_cycle: got %b want 0000",
               {cfg_rdy, locked, ce});
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      e1 = p1[(k-1)%8];
      el = (k == 16);
      checks++;
      if ({ce[0], ce[1], locked, cfg_rdy} !== {1'b1, e1, el, el}) begin
        errors++;
        $display("FAIL reconf_edge%0d: got %b want %b", k,
                 {ce[0], ce[1], locked, cfg_rdy}, {1'b1, e1, el, el});
      end
    end
  endtask

  task automatic test_reject;
    int c1, lo0;
    cfg_en = 1'b1; cfg_ch = 3'd0; cfg_mult = 6'd5; cfg_div = 6'd3;
    @(negedge clk);
    checks++;
    if ({cfg_err, locked} !== 2'b11) begin
      errors++;
      $display("FAIL rej_mgtd: got %b want 11", {cfg_err, locked});
    end
    cfg_ch = 3'd7; cfg_mult = 6'd1; cfg_div = 6'd1;
    @(negedge clk);
    checks++;
    if ({cfg_err, locked} !== 2'b11) begin
      errors++;
      $display("FAIL rej_ch7: got %b want 11", {cfg_err, locked});
    end
    cfg_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({cfg_err, locked} !== 2'b01) begin
      errors++;
      $display("FAIL rej_clear: got %b want 01", {cfg_err, locked});
    end
    c1 = 0; lo0 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ce[1]) c1++;
      if (!ce[0]) lo0++;
    end
    checks++;
    if ({c1, lo0} !== {32'd3, 32'd0}) begin
      errors++;
      $display("FAIL rej_ratios: got c1=%0d lo0=%0d want c1=3 lo0=0",
               c1, lo0);
    end
  endtask
`else
  task automatic test_no_reconfig;
    int c0, bad;
    c0 = 0; bad = 0;
    cfg_en = 1'b1; cfg_ch = 3'd0; cfg_mult = 6'd2; cfg_div = 6'd2;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ce[0]) c0++;
      if ({cfg_rdy, cfg_err, locked} !== 3'b001) bad++;
    end
    cfg_ch = 3'd7; cfg_mult = 6'd5; cfg_div = 6'd3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if ({cfg_rdy, cfg_err, locked} !== 3'b001) bad++;
    end
    cfg_en = 1'b0;
    checks++;
    if (c0 !== 2) begin
      errors++;
      $display("FAIL norcfg_ch0: got %0d want 2", c0);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL norcfg_flags: got %0d bad cycles want 0", bad);
    end
  endtask
`endif

  task automatic test_async_reset;
    logic e0, e1;
`ifdef USER_CLOCK_RECONFIG_EN
    cfg_en = 1'b1; cfg_ch = 3'd0; cfg_mult = 6'd2; cfg_div = 6'd2;
    @(negedge clk);
    cfg_en = 1'b0;
    @(negedge clk);
`else
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif
    repeat (8) @(negedge clk);
    checks++;
    if ({ce, locked} !== 3'b110) begin
      errors++;
      $display("FAIL arst_pre: got %b want 110", {ce, locked});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ce, locked, rst_n_out, cfg_rdy, cfg_err} !== 6'b0) begin
      errors++;
      $display("FAIL arst_clear: got %b want 000000",
               {ce, locked, rst_n_out, cfg_rdy, cfg_err});
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      e0 = (k % 4 == 0);
      e1 = p1[k-1];
      checks++;
      if ({ce[0], ce[1], locked} !== {e0, e1, 1'b0}) begin
        errors++;
        $display("FAIL arst_init%0d: got %b want %b", k,
                 {ce[0], ce[1], locked}, {e0, e1, 1'b0});
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    cfg_en = 1'b0;
    cfg_ch = 3'd0;
    cfg_mult = 6'd0;
    cfg_div = 6'd0;
    errors = 0;
    checks = 0;
    p1 = 8'b1010_0100;
    test_reset;
    test_lock;
    test_density;
`ifdef USER_CLOCK_RECONFIG_EN
    test_reconfig;
    test_reject;
`else
    test_no_reconfig;
`endif
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/user_clock_ratio_gen.md
USER_CLOCK_RATIO_GEN -- requirements
Module: mkUserClock_Ratio_Gen

Interface
REQ-001 Parameter NCH, default 2: number of independent ratio channels, 1-8.
REQ-002 Parameter ACC_W, default 6: width of each channel's multiplier, divisor and phase accumulator.
REQ-003 Parameter LOCK_CYCLES, default 16: stable cycles counted before lock is declared, 1 to 2^16-1.
REQ-004 Parameter INIT_MULT, default {NCH{6'd1}}: packed per-channel reset multiplier M.
REQ-005 Parameter INIT_DIV, default {NCH{6'd2}}: packed per-channel reset divisor D.
REQ-006 CLK  in  1  single clock; all logic rises on CLK.
REQ-007 RST_N  in  1  asynchronous, active-low reset.
REQ-008 CFG_EN  in  1  reconfiguration request, sampled on CLK.
REQ-009 CFG_CH  in  3  target channel index.
REQ-010 CFG_MULT  in  ACC_W  new multiplier M.
REQ-011 CFG_DIV  in  ACC_W  new divisor D.
REQ-012 CFG_RDY  out  1  high when a request can be accepted.
REQ-013 CFG_ERR  out  1  one-cycle pulse flagging a rejected request.
REQ-014 CE_OUT  out  NCH  per-channel clock-enable pulses at M/D of the CLK rate.
REQ-015 LOCKED_OUT  out  1  high while enables are stable.
REQ-016 RST_N_OUT  out  1  active-low reset for the user domain; equals LOCKED_OUT.

Function
REQ-017 The block SHALL run an FSM with states RESET, WAIT_LOCK, LOCKED and RECONFIG.
REQ-018 State transitions:
- RESET -> WAIT_LOCK on the first edge after RST_N deasserts.
- WAIT_LOCK -> LOCKED after LOCK_CYCLES edges.
- LOCKED -> RECONFIG on an accepted request.
- RECONFIG -> WAIT_LOCK after exactly 1 cycle.
REQ-019 In WAIT_LOCK and LOCKED, each channel SHALL compute next = acc + M at ACC_W+1 bits on every edge:
- if next >= D: acc <= next - D and CE_OUT[i] <= 1;
- otherwise: acc <= next and CE_OUT[i] <= 0.
REQ-020 CE_OUT SHALL be registered; pulse density over any D consecutive cycles SHALL equal M exactly.
REQ-021 M == D SHALL give CE_OUT[i] high on every cycle of WAIT_LOCK and LOCKED.
REQ-022 In RESET and RECONFIG, every accumulator and every CE_OUT bit SHALL be cleared to 0.
REQ-023 CFG_RDY SHALL be high only in LOCKED; CFG_EN while CFG_RDY is low SHALL be ignored with no CFG_ERR.
REQ-024 A request SHALL be rejected when any of the following holds: CFG_MULT == 0, CFG_DIV == 0, CFG_MULT > CFG_DIV, or CFG_CH >= NCH.
REQ-025 A rejected request SHALL pulse CFG_ERR on the next cycle and SHALL leave the state, M and D unchanged.
REQ-026 An accepted request SHALL, on the next edge:
- write M and D for channel CFG_CH;
- enter RECONFIG;
- drop LOCKED_OUT and RST_N_OUT;
- clear all channels so their phases stay aligned.
REQ-027 The lock counter SHALL restart from 0 on every entry to WAIT_LOCK.
REQ-028 LOCKED_OUT SHALL assert on the edge that enters LOCKED.

Reset
REQ-029 RST_N low SHALL immediately force all of the following, independent of CLK:
- state RESET;
- CE_OUT = 0, LOCKED_OUT = 0, RST_N_OUT = 0, CFG_RDY = 0, CFG_ERR = 0;
- accumulators and lock counter = 0;
- M/D = INIT_MULT/INIT_DIV.
REQ-030 Reset asserted mid-RECONFIG or mid-WAIT_LOCK SHALL discard reprogrammed ratios and restore the INIT values.

Configuration
REQ-031 Macro USER_CLOCK_RECONFIG_EN defined: runtime reconfiguration operates per REQ-023 to REQ-026.
REQ-032 Macro USER_CLOCK_RECONFIG_EN undefined:
- CFG_* input ports SHALL remain present and be ignored;
- CFG_RDY and CFG_ERR SHALL be tied to 0;
- ratios SHALL be fixed at INIT values and RECONFIG SHALL be unreachable.

Verification
REQ-033 Channel 0 at M=1/D=4, LOCK_CYCLES=16, release RST_N -> CE_OUT[0] pulses one cycle in every 4, first pulse on the 4th edge after entering WAIT_LOCK; LOCKED_OUT and RST_N_OUT rise 16 edges after entering WAIT_LOCK.
REQ-034 Channel 1 at M=3/D=8, run 800 cycles -> exactly 300 pulses, with no two pulses separated by more than 3 idle cycles.
REQ-035 In LOCKED, CFG_EN with CH=0, M=2, D=2 -> CFG_RDY drops, LOCKED_OUT is low for 1+16 cycles, then CE_OUT[0] is high continuously.
REQ-036 CFG_EN with M=5, D=3 and with CH=7 (NCH=2) -> CFG_ERR pulses 1 cycle each time; LOCKED_OUT stays high and ratios are unchanged.
REQ-037 Assert RST_N for 1 ns between edges during WAIT_LOCK after a reconfiguration -> outputs clear asynchronously and INIT ratios return.
REQ-038 Build without USER_CLOCK_RECONFIG_EN and drive valid CFG_EN -> no state change, and CFG_RDY and CFG_ERR are always 0.
